// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing constant, receiver state encoding,
// counter widths and the ASCII codes used in the robot's status messages.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT_115200 = 434;  // 50 MHz / 115200
    localparam int unsigned CNT_W  = 9;                 // bit-timing counter width
    localparam int unsigned IDX_W  = 3;                 // data bit index width
    localparam int unsigned DATA_W = 8;                 // bits per character

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    localparam logic [7:0] ASCII_S      = 8'h53;
    localparam logic [7:0] ASCII_D      = 8'h44;
    localparam logic [7:0] ASCII_P      = 8'h50;
    localparam logic [7:0] ASCII_I      = 8'h49;
    localparam logic [7:0] ASCII_N      = 8'h4E;
    localparam logic [7:0] ASCII_Z      = 8'h5A;
    localparam logic [7:0] ASCII_1      = 8'h31;
    localparam logic [7:0] ASCII_HYPHEN = 8'h2D;
    localparam logic [7:0] ASCII_HASH   = 8'h23;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte-delivery bus between the UART receiver and its consumer.
//   rx_data     : last accepted byte, stable while rx_valid=1
//   rx_valid    : holding-register full flag
//   rx_ack      : consumer acknowledge, clears rx_valid
//   frame_err   : one-cycle pulse, stop bit sampled low
//   overrun_err : one-cycle pulse, good byte dropped because register was full
//   busy        : receiver not idle
// master = receiver side, slave = consumer side.
interface uart_rx_byte_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ack;
    logic              frame_err;
    logic              overrun_err;
    logic              busy;

    modport master (
        output rx_data, rx_valid, frame_err, overrun_err, busy,
        input  rx_ack
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, overrun_err, busy,
        output rx_ack
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
//   clk : destination clock
//   rst : asynchronous active-high reset, both flops load RESET_VAL
//   d   : asynchronous input
//   q   : synchronised output
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with a valid/ack holding register.
//   clk_50 : system clock
//   rst    : asynchronous active-high reset
//   rxin   : serial line, asynchronous, idle high
//   rx_bus : byte-delivery bus (rx_data, rx_valid, rx_ack, frame_err,
//            overrun_err, busy)
// Bits are sampled at their mid-point; the stop bit is judged at its
// mid-point so a start bit immediately following it is still caught.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200
) (
    input  logic           clk_50,
    input  logic           rst,
    input  logic           rxin,
    uart_rx_byte_if.master rx_bus
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    logic              rx_s;
    logic [1:0]        sync_fill;
    logic              armed;
    rx_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              frame_err_q;
    logic              overrun_err_q;
    logic              busy_q;

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk_50),
        .rst (rst),
        .d   (rxin),
        .q   (rx_s)
    );

    // The synchroniser resets to 1, so rx_s only reflects the real line once
    // both flops have reloaded. A start is accepted only after a genuine high
    // has been seen, which keeps a line held low across reset from looking
    // like a falling edge.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            sync_fill <= {sync_fill[0], 1'b1};
            if (sync_fill[1] && rx_s) begin
                armed <= 1'b1;
            end
        end
    end

    // Receive state machine with registered outputs.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
            if (rx_bus.rx_ack) begin
                rx_valid_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s && armed) begin
                        state  <= START;
                        busy_q <= 1'b1;
                    end
                end

                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                        end else begin
                            // Start bit gone by mid-point: a glitch, not a frame.
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rx_s;
                        bit_idx        <= bit_idx + IDX_W'(1);
                        if (bit_idx == IDX_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            // An ack on this same edge frees the register in time.
                            if (!rx_valid_q || rx_bus.rx_ack) begin
                                rx_data_q  <= shreg;
                                rx_valid_q <= 1'b1;
                            end else begin
                                overrun_err_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                WAIT_IDLE: begin
                    cnt <= '0;
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: begin
                    state  <= IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.rx_data     = rx_data_q;
    assign rx_bus.rx_valid    = rx_valid_q;
    assign rx_bus.frame_err   = frame_err_q;
    assign rx_bus.overrun_err = overrun_err_q;
    assign rx_bus.busy        = busy_q;

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte at 16 clocks per bit.
// Expected bytes are queued by the stimulus from the frames it sends and the
// consumer behaviour it chooses; a monitor compares every delivery, hold and
// error pulse against that model.
module tb_uart_rx_byte;
    import uart_pkg::*;

    localparam int unsigned CPB = 16;

    logic clk_50 = 1'b0;
    logic rst;
    logic rxin;

    uart_rx_byte_if bus ();

    uart_rx_byte #(.CLKS_PER_BIT(CPB)) dut (
        .clk_50 (clk_50),
        .rst    (rst),
        .rxin   (rxin),
        .rx_bus (bus)
    );

    always #10 clk_50 = ~clk_50;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         ferr_seen = 0;
    int         oerr_seen = 0;
    bit         auto_ack = 1'b1;
    logic [7:0] seq [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    // Line levels of an 8N1 frame in transmission order: start, d0..d7, stop.
    function automatic logic [9:0] frame_bits(input logic [7:0] b, input logic stop);
        return {stop, b, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50);
        #1;
    endtask

    task automatic drive_bits(input logic [9:0] fb, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rxin = fb[i];
            tick(CPB);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        drive_bits(frame_bits(b, 1'b1), 10);
    endtask

    // Consumer: acknowledges a held byte 3 cycles after it appears when enabled.
    initial begin
        int   age;
        logic pv;
        age = 0;
        pv  = 1'b0;
        bus.rx_ack = 1'b0;
        forever begin
            @(posedge clk_50);
            #1;
            bus.rx_ack = 1'b0;
            if (bus.rx_valid) begin
                age = pv ? age + 1 : 1;
                if (auto_ack && age >= 3) bus.rx_ack = 1'b1;
            end else begin
                age = 0;
            end
            pv = bus.rx_valid;
        end
    end

    // Monitor: checks outputs against the expected-byte queue every cycle.
    initial begin
        logic       pv, pa, pf, po;
        logic [7:0] pd;
        pv = 1'b0; pa = 1'b0; pf = 1'b0; po = 1'b0; pd = 8'h00;
        forever begin
            @(negedge clk_50);
            if (!rst) begin
                if (bus.rx_valid && !pv) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h expected none", bus.rx_data);
                    end else begin
                        check("rx_byte", 32'(bus.rx_data), 32'(exp_q.pop_front()));
                    end
                    check("err_at_valid_rise", 32'({bus.frame_err, bus.overrun_err}), 32'(0));
                end
                if (pv && pa) begin
                    check("ack_clears_valid", 32'(bus.rx_valid), 32'(0));
                end else if (pv && bus.rx_valid) begin
                    check("data_stable", 32'(bus.rx_data), 32'(pd));
                end
                if (bus.frame_err) begin
                    ferr_seen++;
                    check("frame_err_one_cycle", 32'(pf), 32'(0));
                end
                if (bus.overrun_err) begin
                    oerr_seen++;
                    check("overrun_err_one_cycle", 32'(po), 32'(0));
                end
            end
            pv = bus.rx_valid;
            pa = bus.rx_ack;
            pd = bus.rx_data;
            pf = bus.frame_err;
            po = bus.overrun_err;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int f0, o0;
        bit seen;

        seq = '{ASCII_S, ASCII_HYPHEN, ASCII_P, ASCII_HYPHEN, ASCII_D, ASCII_Z,
                ASCII_N, ASCII_1, ASCII_HYPHEN, ASCII_N, ASCII_HYPHEN, ASCII_HASH,
                ASCII_LF};

        rst  = 1'b1;
        rxin = 1'b1;
        tick(5);
        check("reset_rx_data", 32'(bus.rx_data), 32'(8'h00));
        check("reset_rx_valid", 32'(bus.rx_valid), 32'(0));
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_errs", 32'({bus.frame_err, bus.overrun_err}), 32'(0));
        rst = 1'b0;
        tick(10);

        // Single 'S' frame with latency measurement from the falling edge.
        exp_q.push_back(ASCII_S);
        lat = 0;
        fork
            send_byte(ASCII_S);
            begin
                for (int i = 1; i <= 300; i++) begin
                    @(posedge clk_50);
                    #1;
                    if (bus.rx_valid) begin
                        lat = i;
                        break;
                    end
                end
                checks++;
                if (lat < 154 || lat > 156) begin
                    errors++;
                    $display("FAIL s_latency: got %0d cycles expected 155 +/-1", lat);
                end
                check("s_data_literal", 32'(bus.rx_data), 32'(8'h53));
            end
        join
        tick(CPB);
        check("s_no_frame_err", 32'(ferr_seen), 32'(0));
        check("s_no_overrun", 32'(oerr_seen), 32'(0));

        // Status message back-to-back, acked 3 cycles after each delivery.
        for (int i = 0; i < 13; i++) exp_q.push_back(seq[i]);
        for (int i = 0; i < 13; i++) send_byte(seq[i]);
        tick(3 * CPB);
        check("msg_all_delivered", 32'(exp_q.size()), 32'(0));
        check("msg_no_errors", 32'(ferr_seen + oerr_seen), 32'(0));

        // Overrun: two bytes with no acknowledge.
        auto_ack = 1'b0;
        f0 = ferr_seen;
        o0 = oerr_seen;
        exp_q.push_back(ASCII_D);
        send_byte(ASCII_D);
        send_byte(ASCII_Z);
        tick(CPB);
        check("ovr_valid_held", 32'(bus.rx_valid), 32'(1));
        check("ovr_data_kept", 32'(bus.rx_data), 32'(8'h44));
        check("ovr_one_pulse", 32'(oerr_seen - o0), 32'(1));
        check("ovr_no_frame_err", 32'(ferr_seen - f0), 32'(0));
        auto_ack = 1'b1;
        tick(10);
        check("ovr_acked", 32'(bus.rx_valid), 32'(0));

        // Framing error followed by a 40 bit-time break, then a good byte.
        f0 = ferr_seen;
        o0 = oerr_seen;
        drive_bits(frame_bits(ASCII_N, 1'b0), 10);
        rxin = 1'b0;
        tick(40 * CPB);
        rxin = 1'b1;
        tick(2 * CPB);
        check("brk_one_frame_err", 32'(ferr_seen - f0), 32'(1));
        check("brk_no_valid", 32'(bus.rx_valid), 32'(0));
        exp_q.push_back(ASCII_1);
        send_byte(ASCII_1);
        tick(CPB);
        check("brk_recovered", 32'(exp_q.size()), 32'(0));
        check("brk_data_literal", 32'(bus.rx_data), 32'(8'h31));
        check("brk_no_overrun", 32'(oerr_seen - o0), 32'(0));

        // Five-cycle low glitch on an idle line.
        f0 = ferr_seen;
        o0 = oerr_seen;
        seen = 1'b0;
        rxin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus.busy) seen = 1'b1;
        end
        rxin = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.busy) seen = 1'b1;
        end
        check("glitch_busy_seen", 32'(seen), 32'(1));
        check("glitch_back_idle", 32'(bus.busy), 32'(0));
        check("glitch_no_valid", 32'(bus.rx_valid), 32'(0));
        check("glitch_no_errors", 32'((ferr_seen - f0) + (oerr_seen - o0)), 32'(0));

        // Reset during bit 4 of '#', line still low at release.
        f0 = ferr_seen;
        o0 = oerr_seen;
        drive_bits(frame_bits(ASCII_HASH, 1'b1), 5);
        rxin = 1'b0;
        tick(CPB / 2);
        rst = 1'b1;
        tick(2);
        check("rst_mid_rx_data", 32'(bus.rx_data), 32'(8'h00));
        check("rst_mid_valid", 32'(bus.rx_valid), 32'(0));
        check("rst_mid_busy", 32'(bus.busy), 32'(0));
        tick(3);
        rst = 1'b0;
        tick(3 * CPB);
        check("rst_low_line_idle", 32'(bus.busy), 32'(0));
        rxin = 1'b1;
        tick(3 * CPB);
        exp_q.push_back(ASCII_HYPHEN);
        send_byte(ASCII_HYPHEN);
        tick(CPB);
        check("rst_only_new_byte", 32'(exp_q.size()), 32'(0));
        check("rst_data_literal", 32'(bus.rx_data), 32'(8'h2D));
        check("rst_no_errors", 32'((ferr_seen - f0) + (oerr_seen - o0)), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
Asynchronous-serial receiver for the robot's XBee/serial link. It runs at the same 115200-baud, 8N1 framing as the on-board transmitter, with 8 data bits sent LSB first and no parity. It recovers bytes from the rx pin and presents each one on a valid/ack holding register to the command decoder downstream. It also serves as the loopback checker for the transmitter's status messages, such as "S-P-DZN1-N-#<LF>".

Parameters:
CLKS_PER_BIT, 434, clk_50 cycles per bit (50 MHz / 115200); legal range 8..511.
HALF_BIT, CLKS_PER_BIT/2, cycles from detected start edge to the start-bit mid-point check.

Ports:
clk_50  in  1  50 MHz system clock
rst  in  1  reset, asynchronous, active-high
rxin  in  1  serial input, asynchronous to clk_50, idle high
rx_data  out  8  last accepted byte; stable while rx_valid=1
rx_valid  out  1  level, set when a byte is accepted, held until acknowledged
rx_ack  in  1  consumer acknowledge; clears rx_valid on the clock it is sampled high
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun_err  out  1  one-cycle pulse: a good byte completed while rx_valid was still 1
busy  out  1  high in every state except IDLE

Behaviour:
- One clock domain (clk_50); reset is asynchronous and active-high.
- Reset values: rx_data=8'h00, rx_valid=0, frame_err=0, overrun_err=0, busy=0; state=IDLE; counters=0; synchroniser flops=1.
- Input synchronisation: rxin passes through a 2-flop synchroniser to give rx_s. All decisions use rx_s only.
- Bit-timing counter: 9 bits wide. It clears on every state change and counts up to CLKS_PER_BIT-1.
- Bit index: 3 bits wide, counts 0..7.
- State IDLE: stays while rx_s=1. On rx_s=0, moves to START with the counter cleared.
- State START: when the counter reaches HALF_BIT-1, sample rx_s.
  - rx_s=0: go to DATA.
  - rx_s=1: treat as a glitch; return to IDLE with no flags raised.
- State DATA: each time the counter reaches CLKS_PER_BIT-1, shift rx_s into bit[index] and advance the index. After index 7 is sampled, go to STOP.
- State STOP: when the counter reaches CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 and rx_valid=0: load rx_data and set rx_valid on the next edge.
  - rx_s=1 and rx_valid=1: pulse overrun_err. The new byte is dropped and the old rx_data is kept.
  - In both rx_s=1 cases, go to IDLE.
  - rx_s=0: pulse frame_err, discard the byte, go to WAIT_IDLE.
- State WAIT_IDLE: stays until rx_s=1, then goes to IDLE. A held-low (break) line therefore produces exactly one frame_err and no further bytes.
- Latency: rx_valid rises 2 (synchroniser) + HALF_BIT + 9*CLKS_PER_BIT + 1 cycles after the falling edge on rxin, within ±1 cycle.
- Simultaneous events:
  - rx_ack=1 on the same edge a new byte completes: the new byte is accepted, rx_valid stays 1, rx_data updates, and no overrun_err.
  - rx_ack while rx_valid=0 is ignored.
- Back-to-back frames: a start bit immediately after a stop bit is caught, because the STOP-to-IDLE transition happens at the stop-bit mid-point.
- Reset asserted mid-frame: all state returns to reset values immediately, and any partial byte is lost. After release, the receiver resynchronises only on a subsequent high-to-low edge seen from IDLE. If the line is low at release, no byte is produced until the line has been seen high.
- Error pulses last exactly one clk_50 cycle and never coincide with a rx_valid rising edge.

Decomposition:
- Shared package uart_pkg: CLKS_PER_BIT_115200=434; the rx state enum (IDLE, START, DATA, STOP, WAIT_IDLE); ASCII constants already used by the transmitter (S, D, P, I, N, Z, 1, hyphen, hash, LF).
- One natural sub-module: uart_sync2, the 2-flop synchroniser with a reset value of 1, reusable for other asynchronous inputs.

Test Plan:
- Run with CLKS_PER_BIT=16. Drive 8N1 frame 0x53 ('S') → rx_valid rises with rx_data=8'h53 within ±1 cycle of 2+8+144+1 cycles. No error pulses.
- Drive the 13-byte sequence "S-P-DZN1-N-#"+0x0A back-to-back, acking each byte 3 cycles after rx_valid → 13 bytes in exact order, zero errors.
- Drive 0x44 then 0x5A with no rx_ack → first byte shows 8'h44. At the second stop mid-point, overrun_err pulses once and rx_data stays 8'h44.
- Drive 0x4E with the stop bit forced to 0, then hold the line low for 40 bit-times → one frame_err pulse and no rx_valid. The next valid frame 0x31 is received correctly once the line returns high.
- Apply a 5-cycle low glitch on idle rxin → busy pulses, then returns to IDLE. No rx_valid and no error.
- Assert rst at bit 4 of frame 0x23, release it, then send 0x2D → outputs at reset values during reset; only 8'h2D is delivered afterwards.
